// File: rtl/store_lane_packer_if.sv
// Store-side bus for store_lane_packer: the store request from MEM decode and the
// posted-write drain port toward data memory.
interface store_lane_packer_if;
  logic        st_valid;
  logic [1:0]  st_mode;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        align_err;
  logic        buf_empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  modport slave (
    input  st_valid, st_mode, st_addr, st_data, mem_ack,
    output st_ready, align_err, buf_empty, mem_req, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output st_valid, st_mode, st_addr, st_data, mem_ack,
    input  st_ready, align_err, buf_empty, mem_req, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/store_lane_packer.sv
// Packs sw/sh/sb operands into byte lanes + enables and queues them in a posted-write FIFO.
// Optional misaligned-store rejection is enabled by defining STORE_ALIGN_CHECK_EN.
module store_lane_packer #(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  store_lane_packer_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [29:0]   r_addr [DEPTH];
  logic [3:0]    r_be   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic          w_store;
  logic          w_aligned;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_be;
  logic [31:0]   w_data;

  always_comb begin
    w_be   = 4'b0000;
    w_data = bus.st_data;
    case (bus.st_mode)
      2'b01: begin
        w_be   = 4'b1111;
        w_data = bus.st_data;
      end
      2'b10: begin
        w_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        w_data = {2{bus.st_data[15:0]}};
      end
      2'b11: begin
        w_be   = 4'b0001 << bus.st_addr[1:0];
        w_data = {4{bus.st_data[7:0]}};
      end
      default: begin
        w_be   = 4'b0000;
        w_data = bus.st_data;
      end
    endcase
  end

  assign w_store      = bus.st_valid && (bus.st_mode != 2'b00);
  assign bus.st_ready = (r_count != FULL);
  assign w_push       = w_store && bus.st_ready && w_aligned;
  assign w_pop        = bus.mem_req && bus.mem_ack;

`ifdef STORE_ALIGN_CHECK_EN
  logic r_align_err;

  always_comb begin
    w_aligned = 1'b1;
    if (bus.st_mode == 2'b01 && bus.st_addr[1:0] != 2'b00) w_aligned = 1'b0;
    if (bus.st_mode == 2'b10 && bus.st_addr[0])            w_aligned = 1'b0;
  end

  // Stores refused for lack of space are retried upstream, so they never flag an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_align_err <= 1'b0;
    else       r_align_err <= w_store && bus.st_ready && !w_aligned;
  end

  assign bus.align_err = r_align_err;
`else
  assign w_aligned     = 1'b1;
  assign bus.align_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; outputs are gated by mem_req instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr[31:2];
      r_be[r_tail]   <= w_be;
      r_data[r_tail] <= w_data;
    end
  end

  assign bus.mem_req   = (r_count != '0);
  assign bus.buf_empty = (r_count == '0);
  assign bus.mem_addr  = bus.mem_req ? {r_addr[r_head], 2'b00} : 32'h0;
  assign bus.mem_be    = bus.mem_req ? r_be[r_head]            : 4'h0;
  assign bus.mem_wdata = bus.mem_req ? r_data[r_head]          : 32'h0;

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed scoreboard bench for store_lane_packer (DEPTH=4).
module tb_store_lane_packer;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  store_lane_packer_if bus();

  store_lane_packer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    ent_t e;
    e.a  = a;
    e.be = be;
    e.d  = d;
    q.push_back(e);
  endtask

  task automatic check_head(input string tag);
    ent_t e;
    chk({tag, "_req"}, {31'b0, bus.mem_req}, 32'd1);
    if (q.size() == 0) begin
      n_total++;
      $error("FAIL %s_sb: observed empty scoreboard expected pending entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_addr"}, bus.mem_addr, e.a);
      chk({tag, "_be"},   {28'b0, bus.mem_be}, {28'b0, e.be});
      chk({tag, "_data"}, bus.mem_wdata, e.d);
    end
  endtask

  task automatic drive_store(input logic [1:0] mode, input logic [31:0] addr,
                             input logic [31:0] data, input logic ack, input string tag);
    if (ack) check_head(tag);
    bus.st_valid = 1'b1;
    bus.st_mode  = mode;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.mem_ack  = ack;
    step();
    bus.st_valid = 1'b0;
    bus.st_mode  = 2'b00;
    bus.mem_ack  = 1'b0;
    #1;
  endtask

  task automatic ack_one(input string tag);
    check_head(tag);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_mode  = 2'b00;
    bus.st_addr  = 32'h0;
    bus.st_data  = 32'h0;
    bus.mem_ack  = 1'b0;
    #12;
    chk("rst_ready", {31'b0, bus.st_ready},  32'd1);
    chk("rst_empty", {31'b0, bus.buf_empty}, 32'd1);
    chk("rst_req",   {31'b0, bus.mem_req},   32'd0);
    chk("rst_aerr",  {31'b0, bus.align_err}, 32'd0);
    chk("rst_maddr", bus.mem_addr,  32'h0);
    chk("rst_mbe",   {28'b0, bus.mem_be}, 32'h0);
    chk("rst_mdata", bus.mem_wdata, 32'h0);
    step();
    reset = 1'b0;
    #1;

    // single sb, one-cycle latency
    exp_push(32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
    drive_store(2'b11, 32'h0000_1003, 32'h1234_56AB, 1'b0, "sb3");
    chk("sb3_empty", {31'b0, bus.buf_empty}, 32'd0);
    ack_one("sb3");
    chk("sb3_drained", {31'b0, bus.buf_empty}, 32'd1);

    // fill with mixed widths
    exp_push(32'h0000_0000, 4'b1100, 32'hBEEF_BEEF);
    drive_store(2'b10, 32'h0000_0002, 32'hFFFF_BEEF, 1'b0, "sh_hi");
    exp_push(32'h0000_0004, 4'b0011, 32'h5678_5678);
    drive_store(2'b10, 32'h0000_0004, 32'h1234_5678, 1'b0, "sh_lo");
    exp_push(32'h0000_0020, 4'b0010, 32'h5A5A_5A5A);
    drive_store(2'b11, 32'h0000_0021, 32'hFFFF_FF5A, 1'b0, "sb1");
    exp_push(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
    drive_store(2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "sw");
    chk("full_ready", {31'b0, bus.st_ready}, 32'd0);

    // a fifth store held while full is not captured
    bus.st_valid = 1'b1;
    bus.st_mode  = 2'b01;
    bus.st_addr  = 32'h0000_0040;
    bus.st_data  = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_ready", {31'b0, bus.st_ready}, 32'd0);
      chk("held_aerr",  {31'b0, bus.align_err}, 32'd0);
    end
    bus.st_valid = 1'b0;
    bus.st_mode  = 2'b00;
    #1;
    ack_one("drain0");
    chk("drain0_ready", {31'b0, bus.st_ready}, 32'd1);
    ack_one("drain1");
    ack_one("drain2");
    chk("drain2_empty", {31'b0, bus.buf_empty}, 32'd0);
    ack_one("drain3");
    chk("drain3_empty", {31'b0, bus.buf_empty}, 32'd1);

    // simultaneous push and pop with two buffered
    exp_push(32'h0000_0100, 4'b1111, 32'h1111_1111);
    drive_store(2'b01, 32'h0000_0100, 32'h1111_1111, 1'b0, "pp_a");
    exp_push(32'h0000_0200, 4'b1111, 32'h2222_2222);
    drive_store(2'b01, 32'h0000_0200, 32'h2222_2222, 1'b0, "pp_b");
    exp_push(32'h0000_0300, 4'b1111, 32'h3333_3333);
    drive_store(2'b01, 32'h0000_0300, 32'h3333_3333, 1'b1, "pp_c");
    ack_one("pp_b");
    chk("pp_one_left", {31'b0, bus.buf_empty}, 32'd0);
    ack_one("pp_c");
    chk("pp_empty", {31'b0, bus.buf_empty}, 32'd1);

    // full with a pop in the same cycle still refuses the store
    for (int i = 0; i < 4; i++) begin
      exp_push(32'h0000_0400 + 32'(4 * i), 4'b1111, 32'hA000_0000 + 32'(i));
      drive_store(2'b01, 32'h0000_0400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, "fp_fill");
    end
    drive_store(2'b01, 32'h0000_0500, 32'hBAD0_BAD0, 1'b1, "fp_pop");
    chk("fp_ready", {31'b0, bus.st_ready}, 32'd1);
    ack_one("fp_d1");
    ack_one("fp_d2");
    ack_one("fp_d3");
    chk("fp_empty", {31'b0, bus.buf_empty}, 32'd1);

    // mode 00 is not a store; ack on an empty buffer is ignored
    drive_store(2'b00, 32'h0000_0600, 32'h0, 1'b0, "m00");
    chk("m00_empty", {31'b0, bus.buf_empty}, 32'd1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("idle_ack_empty", {31'b0, bus.buf_empty}, 32'd1);
    chk("idle_ack_ready", {31'b0, bus.st_ready},  32'd1);
    exp_push(32'h0000_0610, 4'b0100, 32'h7777_7777);
    drive_store(2'b11, 32'h0000_0612, 32'h0000_0077, 1'b0, "after_idle");
    ack_one("after_idle");
    chk("after_idle_empty", {31'b0, bus.buf_empty}, 32'd1);

    // misaligned stores
`ifdef STORE_ALIGN_CHECK_EN
    drive_store(2'b01, 32'h0000_0602, 32'hCAFE_F00D, 1'b0, "mis_sw");
    chk("mis_sw_aerr",  {31'b0, bus.align_err}, 32'd1);
    chk("mis_sw_empty", {31'b0, bus.buf_empty}, 32'd1);
    step();
    chk("mis_sw_aerr_end", {31'b0, bus.align_err}, 32'd0);
    drive_store(2'b10, 32'h0000_0603, 32'hCAFE_F00D, 1'b0, "mis_sh");
    chk("mis_sh_aerr",  {31'b0, bus.align_err}, 32'd1);
    chk("mis_sh_empty", {31'b0, bus.buf_empty}, 32'd1);
    exp_push(32'h0000_0600, 4'b1100, 32'hF00D_F00D);
    drive_store(2'b10, 32'h0000_0602, 32'hCAFE_F00D, 1'b0, "ok_sh");
    chk("ok_sh_aerr", {31'b0, bus.align_err}, 32'd0);
    ack_one("ok_sh");
`else
    exp_push(32'h0000_0600, 4'b1111, 32'hCAFE_F00D);
    drive_store(2'b01, 32'h0000_0602, 32'hCAFE_F00D, 1'b0, "mis_sw");
    chk("mis_sw_aerr", {31'b0, bus.align_err}, 32'd0);
    ack_one("mis_sw");
    exp_push(32'h0000_0600, 4'b1100, 32'hF00D_F00D);
    drive_store(2'b10, 32'h0000_0603, 32'hCAFE_F00D, 1'b0, "mis_sh");
    chk("mis_sh_aerr", {31'b0, bus.align_err}, 32'd0);
    ack_one("mis_sh");
`endif

    // reset mid-drain discards everything asynchronously
    for (int i = 0; i < 3; i++) begin
      exp_push(32'h0000_0700 + 32'(4 * i), 4'b1111, 32'hC000_0000 + 32'(i));
      drive_store(2'b01, 32'h0000_0700 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, "rd_fill");
    end
    chk("rd_req_before", {31'b0, bus.mem_req}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rd_req",   {31'b0, bus.mem_req},   32'd0);
    chk("rd_empty", {31'b0, bus.buf_empty}, 32'd1);
    chk("rd_ready", {31'b0, bus.st_ready},  32'd1);
    chk("rd_maddr", bus.mem_addr, 32'h0);
    q.delete();
    step();
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    step();
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("rd_ack_req",   {31'b0, bus.mem_req},   32'd0);
    chk("rd_ack_empty", {31'b0, bus.buf_empty}, 32'd1);
    exp_push(32'h0000_0800, 4'b0001, 32'h3C3C_3C3C);
    drive_store(2'b11, 32'h0000_0800, 32'h0000_003C, 1'b0, "post_rst");
    ack_one("post_rst");
    chk("post_rst_empty", {31'b0, bus.buf_empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
